// File: rtl/dpram_loader_pkg.sv
// Shared types for the dual-port RAM loader: FSM state encoding and checksum width.
// Build option DPRAM_LOADER_CLEAR_EN (see dpram_loader) enables the zero-fill pass.
package dpram_loader_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StClear,
        StLoad,
        StDone
    } state_e;

    localparam int unsigned ChecksumWidth = 16;

endpackage

// File: rtl/dpram_loader_window.sv
// Combinational address window: flags ioctl addresses inside the RAM image and
// converts them to a RAM-relative address.
module dpram_loader_window #(
    parameter int unsigned address_width = 10,
    parameter int unsigned base_address  = 0
) (
    input  logic [24:0]              addr_i,
    output logic                     hit_o,
    output logic [address_width-1:0] ram_addr_o
);

    // One extra bit so base + depth cannot wrap at the top of the 25-bit space.
    localparam logic [25:0] Base  = 26'(base_address);
    localparam logic [25:0] Limit = Base + (26'd1 << address_width);

    assign hit_o      = ({1'b0, addr_i} >= Base) && ({1'b0, addr_i} < Limit);
    assign ram_addr_o = address_width'(addr_i - Base[24:0]);

endmodule

// File: rtl/dpram_loader.sv
// Write-side master filling a dual-port RAM from the ioctl download stream.
// Define DPRAM_LOADER_CLEAR_EN to zero-fill the RAM before each load.
module dpram_loader
    import dpram_loader_pkg::*;
#(
    parameter int unsigned address_width = 10,
    parameter int unsigned target_index  = 0,
    parameter int unsigned base_address  = 0
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     ioctl_download,
    input  logic [7:0]               ioctl_index,
    input  logic                     ioctl_wr,
    input  logic [24:0]              ioctl_addr,
    input  logic [7:0]               ioctl_dout,
    output logic                     ioctl_wait,
    output logic                     ram_enable,
    output logic                     ram_wren,
    output logic [address_width-1:0] ram_address,
    output logic [7:0]               ram_data,
    output logic                     busy,
    output logic                     done,
    output logic [15:0]              checksum,
    output logic                     dropped
);

    localparam logic [7:0] TargetIdx = 8'(target_index);

    state_e                     state_q;
    logic                       dl_q;
    logic                       we_q;
    logic [address_width-1:0]   addr_q;
    logic [7:0]                 data_q;
    logic [ChecksumWidth-1:0]   checksum_q;
    logic                       dropped_q;

    logic                       win_hit;
    logic [address_width-1:0]   win_addr;
    logic                       idx_match;
    logic                       start;
    logic                       wr_acc;

    assign idx_match = (ioctl_index == TargetIdx);
    assign start     = ioctl_download & ~dl_q & idx_match;
    assign wr_acc    = ioctl_wr & idx_match;

    dpram_loader_window #(
        .address_width (address_width),
        .base_address  (base_address)
    ) u_window (
        .addr_i     (ioctl_addr),
        .hit_o      (win_hit),
        .ram_addr_o (win_addr)
    );

`ifdef DPRAM_LOADER_CLEAR_EN
    localparam logic [address_width-1:0] ClearLast = '1;

    logic                     pend_valid_q, pend_valid_d;
    logic [address_width-1:0] pend_addr_q, pend_addr_d;
    logic [7:0]               pend_data_q, pend_data_d;
    logic                     pend_drop;

    // Strobes that arrive while clearing are parked in a single-entry buffer.
    always_comb begin
        pend_valid_d = pend_valid_q;
        pend_addr_d  = pend_addr_q;
        pend_data_d  = pend_data_q;
        pend_drop    = 1'b0;
        if (state_q == StClear && wr_acc) begin
            if (!win_hit || pend_valid_q) begin
                pend_drop = 1'b1;
            end else begin
                pend_valid_d = 1'b1;
                pend_addr_d  = win_addr;
                pend_data_d  = ioctl_dout;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pend_valid_q <= 1'b0;
            pend_addr_q  <= '0;
            pend_data_q  <= '0;
        end else begin
            if (state_q == StClear && addr_q == ClearLast) begin
                pend_valid_q <= 1'b0;
            end else begin
                pend_valid_q <= pend_valid_d;
            end
            pend_addr_q <= pend_addr_d;
            pend_data_q <= pend_data_d;
        end
    end
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            dl_q       <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            checksum_q <= '0;
            dropped_q  <= 1'b0;
        end else begin
            dl_q <= ioctl_download;
            case (state_q)
                StIdle: begin
                    we_q <= 1'b0;
                    if (start) begin
                        checksum_q <= '0;
                        dropped_q  <= 1'b0;
`ifdef DPRAM_LOADER_CLEAR_EN
                        state_q <= StClear;
                        we_q    <= 1'b1;
                        addr_q  <= '0;
                        data_q  <= '0;
`else
                        state_q <= StLoad;
`endif
                    end
                end
`ifdef DPRAM_LOADER_CLEAR_EN
                StClear: begin
                    if (pend_drop) begin
                        dropped_q <= 1'b1;
                    end
                    if (addr_q == ClearLast) begin
                        // The parked byte (or one arriving right now) lands in the first LOAD cycle.
                        we_q <= pend_valid_d;
                        if (pend_valid_d) begin
                            addr_q     <= pend_addr_d;
                            data_q     <= pend_data_d;
                            checksum_q <= checksum_q + ChecksumWidth'(pend_data_d);
                        end
                        state_q <= (!ioctl_download && !pend_valid_d) ? StDone : StLoad;
                    end else begin
                        addr_q <= addr_q + address_width'(1);
                    end
                end
`endif
                StLoad: begin
                    if (wr_acc) begin
                        we_q <= win_hit;
                        if (win_hit) begin
                            addr_q     <= win_addr;
                            data_q     <= ioctl_dout;
                            checksum_q <= checksum_q + ChecksumWidth'(ioctl_dout);
                        end else begin
                            dropped_q <= 1'b1;
                        end
                    end else begin
                        we_q <= 1'b0;
                        if (!ioctl_download) begin
                            state_q <= StDone;
                        end
                    end
                end
                StDone: begin
                    we_q    <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    we_q    <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

`ifdef DPRAM_LOADER_CLEAR_EN
    assign ioctl_wait = (state_q == StClear);
`else
    assign ioctl_wait = 1'b0;
`endif
    assign ram_enable  = we_q;
    assign ram_wren    = we_q;
    assign ram_address = addr_q;
    assign ram_data    = data_q;
    assign busy        = (state_q == StClear) || (state_q == StLoad);
    assign done        = (state_q == StDone);
    assign checksum    = checksum_q;
    assign dropped     = dropped_q;

endmodule

// File: tb/tb_dpram_loader.sv
// Directed bench for dpram_loader: a 16-byte instance at base 0x100 and a 1024-byte
// instance at base 0, each with its own download line and shared ioctl data lines.
module tb_dpram_loader;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        dl_a = 1'b0;
    logic        dl_b = 1'b0;
    logic [7:0]  ioctl_index = 8'd0;
    logic        ioctl_wr = 1'b0;
    logic [24:0] ioctl_addr = '0;
    logic [7:0]  ioctl_dout = 8'd0;

    logic        a_wait, a_en, a_wren, a_busy, a_done, a_drop;
    logic [3:0]  a_addr;
    logic [7:0]  a_data;
    logic [15:0] a_cks;
    logic        b_wait, b_en, b_wren, b_busy, b_done, b_drop;
    logic [9:0]  b_addr;
    logic [7:0]  b_data;
    logic [15:0] b_cks;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] ram_b [1024];

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (b_en && b_wren) ram_b[b_addr] <= b_data;
    end

    dpram_loader #(
        .address_width (4),
        .target_index  (0),
        .base_address  (32'h100)
    ) u_dut_a (
        .clock          (clock),
        .reset_n        (reset_n),
        .ioctl_download (dl_a),
        .ioctl_index    (ioctl_index),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .ioctl_wait     (a_wait),
        .ram_enable     (a_en),
        .ram_wren       (a_wren),
        .ram_address    (a_addr),
        .ram_data       (a_data),
        .busy           (a_busy),
        .done           (a_done),
        .checksum       (a_cks),
        .dropped        (a_drop)
    );

    dpram_loader #(
        .address_width (10),
        .target_index  (0),
        .base_address  (0)
    ) u_dut_b (
        .clock          (clock),
        .reset_n        (reset_n),
        .ioctl_download (dl_b),
        .ioctl_index    (ioctl_index),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .ioctl_wait     (b_wait),
        .ram_enable     (b_en),
        .ram_wren       (b_wren),
        .ram_address    (b_addr),
        .ram_data       (b_data),
        .busy           (b_busy),
        .done           (b_done),
        .checksum       (b_cks),
        .dropped        (b_drop)
    );

    typedef struct {
        logic [24:0] addr;
        logic [7:0]  data;
        logic        exp_we;
        logic [3:0]  exp_addr;
        logic [15:0] exp_cks;
        logic        exp_drop;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Called right after dl_a rises; returns at the negedge of the first LOAD cycle.
    task automatic clear_a(input bit inject);
`ifdef DPRAM_LOADER_CLEAR_EN
        for (int i = 0; i < 16; i++) begin
            @(negedge clock);
            check("clr_we", 32'({a_en, a_wren}), 32'h3);
            check("clr_addr", 32'(a_addr), 32'(i));
            check("clr_data", 32'(a_data), 32'h0);
            check("clr_wait", 32'(a_wait), 32'h1);
            if (inject) begin
                if (i == 3) begin
                    ioctl_wr = 1'b1; ioctl_addr = 25'h100; ioctl_dout = 8'h12;
                end else if (i == 6) begin
                    ioctl_wr = 1'b1; ioctl_addr = 25'h101; ioctl_dout = 8'h77;
                end else begin
                    ioctl_wr = 1'b0;
                end
            end
        end
`endif
        @(negedge clock);
        ioctl_wr = 1'b0;
        check("load_busy", 32'(a_busy), 32'h1);
        check("load_wait", 32'(a_wait), 32'h0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, got no finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int k;
        int cnt;

        vecs[0] = '{25'h100, 8'hAA, 1'b1, 4'd0,  16'h00AA, 1'b0};
        vecs[1] = '{25'h10F, 8'h55, 1'b1, 4'd15, 16'h00FF, 1'b0};
        vecs[2] = '{25'h110, 8'h33, 1'b0, 4'd0,  16'h00FF, 1'b1};
        vecs[3] = '{25'h0FF, 8'h44, 1'b0, 4'd0,  16'h00FF, 1'b1};
        vecs[4] = '{25'h105, 8'h01, 1'b1, 4'd5,  16'h0100, 1'b1};
        vecs[5] = '{25'h10A, 8'hFF, 1'b1, 4'd10, 16'h01FF, 1'b1};

        // Reset state
        #3;
        check("rst_we", 32'({a_en, a_wren}), 32'h0);
        check("rst_addr_data", 32'({a_addr, a_data}), 32'h0);
        check("rst_flags", 32'({a_wait, a_busy, a_done, a_drop}), 32'h0);
        check("rst_cks", 32'(a_cks), 32'h0);
        check("rst_b", 32'({b_en, b_wren, b_addr, b_data, b_cks, b_busy, b_done}), 32'h0);
        @(negedge clock);
        reset_n = 1'b1;

        // Window filtering and checksum, one strobe per vector
        @(negedge clock);
        dl_a = 1'b1;
        clear_a(1'b0);
        check("load_first_we", 32'(a_wren), 32'h0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            ioctl_wr = 1'b1; ioctl_addr = vecs[i].addr; ioctl_dout = vecs[i].data;
            @(negedge clock);
            ioctl_wr = 1'b0;
            check($sformatf("v%0d_en", i), 32'(a_en), 32'(vecs[i].exp_we));
            check($sformatf("v%0d_wren", i), 32'(a_wren), 32'(vecs[i].exp_we));
            if (vecs[i].exp_we) begin
                check($sformatf("v%0d_addr", i), 32'(a_addr), 32'(vecs[i].exp_addr));
                check($sformatf("v%0d_data", i), 32'(a_data), 32'(vecs[i].data));
            end
            check($sformatf("v%0d_cks", i), 32'(a_cks), 32'(vecs[i].exp_cks));
            check($sformatf("v%0d_drop", i), 32'(a_drop), 32'(vecs[i].exp_drop));
        end
        @(negedge clock);
        dl_a = 1'b0;
        @(negedge clock);
        check("a_done_pulse", 32'({a_done, a_busy, a_wren}), 32'h4);
        @(negedge clock);
        check("a_done_gone", 32'({a_done, a_busy}), 32'h0);

`ifdef DPRAM_LOADER_CLEAR_EN
        // Strobes during CLEAR: first is parked and flushed, second is dropped
        @(negedge clock);
        dl_a = 1'b1;
        clear_a(1'b1);
        check("pend_we", 32'(a_wren), 32'h1);
        check("pend_addr", 32'(a_addr), 32'h0);
        check("pend_data", 32'(a_data), 32'h12);
        check("pend_cks", 32'(a_cks), 32'h12);
        check("pend_drop", 32'(a_drop), 32'h1);
        @(negedge clock);
        check("pend_second_not_written", 32'(a_wren), 32'h0);
        dl_a = 1'b0;
        @(negedge clock);
        check("pend_done", 32'(a_done), 32'h1);
        @(negedge clock);
`endif

        // 300 back-to-back bytes into the 1024-deep instance
        @(negedge clock);
        dl_b = 1'b1;
        k = 0;
        do begin
            @(negedge clock);
            k++;
        end while (b_wait && k < 2000);
        check("b_clear_ends", 32'(k < 2000), 32'h1);
        check("b_busy", 32'(b_busy), 32'h1);
        cnt = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clock);
            if (i > 0 && b_en && b_wren) cnt++;
            ioctl_wr = 1'b1; ioctl_addr = 25'(i); ioctl_dout = 8'hFF;
        end
        @(negedge clock);
        if (b_en && b_wren) cnt++;
        check("b_last_addr", 32'(b_addr), 32'd299);
        check("b_last_data", 32'(b_data), 32'hFF);
        ioctl_wr = 1'b0;
        dl_b = 1'b0;
        check("b_write_count", 32'(cnt), 32'd300);
        @(negedge clock);
        check("b_done_pulse", 32'({b_done, b_wren}), 32'h2);
        check("b_cks", 32'(b_cks), 32'h2AD4);
        check("b_drop", 32'(b_drop), 32'h0);
        @(negedge clock);
        check("b_idle", 32'({b_done, b_busy}), 32'h0);
        check("b_ram0", 32'(ram_b[0]), 32'hFF);
        check("b_ram299", 32'(ram_b[299]), 32'hFF);

        // Asynchronous reset mid-LOAD
        @(negedge clock);
        dl_a = 1'b1;
        k = 0;
        do begin
            @(negedge clock);
            k++;
        end while (a_wait && k < 100);
        check("a_clear_ends", 32'(k < 100), 32'h1);
        ioctl_wr = 1'b1; ioctl_addr = 25'h103; ioctl_dout = 8'h5A;
        @(negedge clock);
        ioctl_wr = 1'b0;
        check("mid_we", 32'(a_wren), 32'h1);
        check("mid_addr", 32'(a_addr), 32'h3);
        check("mid_cks", 32'(a_cks), 32'h5A);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_we", 32'({a_en, a_wren}), 32'h0);
        check("arst_addr_data", 32'({a_addr, a_data}), 32'h0);
        check("arst_cks", 32'(a_cks), 32'h0);
        check("arst_flags", 32'({a_wait, a_busy, a_done, a_drop}), 32'h0);
        @(negedge clock);
        reset_n = 1'b1;
        dl_a = 1'b0;
        ioctl_index = 8'd1;
        @(negedge clock);
        dl_a = 1'b1;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (a_en || a_wren || a_busy || a_wait || a_done) cnt++;
            ioctl_wr = i[0];
            ioctl_addr = 25'h100 + 25'(i);
            ioctl_dout = 8'(i);
        end
        ioctl_wr = 1'b0;
        @(negedge clock);
        if (a_en || a_wren || a_busy || a_wait || a_done) cnt++;
        check("idx1_no_activity", 32'(cnt), 32'h0);
        check("idx1_cks", 32'(a_cks), 32'h0);
        check("idx1_drop", 32'(a_drop), 32'h0);
        dl_a = 1'b0;
        ioctl_index = 8'd0;
        @(negedge clock);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
